md_unit: RTL and testbench

- Multi-cycle multiply/divide unit with architectural HI/LO registers. It sits in the EX stage beside the ALU.
- It produces the `busy` and `md_pending` status that the hazard/stall logic consumes. While `md_pending` is high, that logic stalls any MFHI/MFLO/MTHI/MTLO/MULT/DIV instruction sitting in ID.
- It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.

---
 rtl/md_unit.sv | 213 +++++++++++++++++++++
 tb/tb_md_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit -- multi-cycle multiply/divide unit with architectural HI/LO.
//
// Sits beside the ALU in EX. A MULT/MULTU/DIV/DIVU accepted on a start edge
// has its full 64-bit result computed at once into a pending register. busy
// then stays high for MULT_CYCLES or DIV_CYCLES cycles, and the pending value
// is committed to HI/LO on the edge that ends the run. HI/LO keep their old
// contents for the whole run, so the architectural state only ever changes
// at a commit or a move.
//
// Parameters:
//   MULT_CYCLES  busy length for MULT/MULTU (1..15)
//   DIV_CYCLES   busy length for DIV/DIVU   (1..15)
//
// Optional feature (macro MD_CANCEL_EN):
//   Adds input `cancel`. In RUN it aborts the operation and drops the pending
//   result. In IDLE it blocks start/mthi/mtlo on that edge. Without the macro
//   an operation always runs to completion unless reset_n is asserted.
//
// Ports:
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   start       unstalled MULT/MULTU/DIV/DIVU in EX this cycle
//   md_op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   mthi, mtlo  write `a` into HI / LO (IDLE only, start has priority)
//   cancel      (MD_CANCEL_EN only) kill in-flight operation
//   a, b        forwarded rs / rt operands
//   busy        operation in flight (registered)
//   md_pending  start | busy, combinational, for the stall logic
//   hi, lo      architectural HI / LO registers
// -----------------------------------------------------------------------------
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic        mthi,
    input  logic        mtlo,
`ifdef MD_CANCEL_EN
    input  logic        cancel,
`endif
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        md_pending,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // Counter reload values: the counter runs N-1 .. 0, so busy is high for N.
    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_reg;
    logic [3:0]  counter_reg;
    logic [63:0] pending_reg;
    logic        busy_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    logic        cancel_req;

`ifdef MD_CANCEL_EN
    assign cancel_req = cancel;
`else
    assign cancel_req = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Operand decode
    // -------------------------------------------------------------------------
    logic is_div;
    logic is_unsigned;
    logic sign_a;
    logic sign_b;

    assign is_div      = md_op[1];
    assign is_unsigned = md_op[0];
    // Operand is negative only when interpreted as a signed value.
    assign sign_a      = ~is_unsigned & a[31];
    assign sign_b      = ~is_unsigned & b[31];

    // -------------------------------------------------------------------------
    // Multiply: sign- or zero-extend both operands to 64 bits; the low 64 bits
    // of the unsigned product of the extended values equal the signed product
    // in two's complement, so one multiplier serves MULT and MULTU.
    // -------------------------------------------------------------------------
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] mul_result;

    assign mul_a      = {{32{sign_a}}, a};
    assign mul_b      = {{32{sign_b}}, b};
    assign mul_result = mul_a * mul_b;

    // -------------------------------------------------------------------------
    // Divide: unsigned divide of magnitudes, then restore signs. The quotient
    // is negative when operand signs differ; the remainder follows the
    // dividend. 0x80000000 / -1 needs no special case: its magnitude is
    // 0x80000000 unsigned, the quotient is 0x80000000, and negating that
    // wraps back to 0x80000000 with remainder 0.
    // -------------------------------------------------------------------------
    logic [31:0] div_dvd;
    logic [31:0] div_dvs;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_by_zero;
    logic [63:0] div_result;

    assign div_dvd     = sign_a ? (~a + 32'd1) : a;
    assign div_dvs     = sign_b ? (~b + 32'd1) : b;
    assign div_by_zero = (b == 32'd0);

    // Guard the divider so a zero divisor never produces X in simulation;
    // the zero-divisor result is substituted below anyway.
    assign div_q = div_by_zero ? 32'd0 : (div_dvd / div_dvs);
    assign div_r = div_by_zero ? 32'd0 : (div_dvd % div_dvs);

    assign quot  = (sign_a ^ sign_b) ? (~div_q + 32'd1) : div_q;
    assign rem   = sign_a ? (~div_r + 32'd1) : div_r;

    always_comb begin
        div_result = {rem, quot};
        if (div_by_zero) begin
            // No trap: LO saturates to all ones, HI echoes the dividend.
            div_result = {a, 32'hFFFF_FFFF};
        end
    end

    // -------------------------------------------------------------------------
    // Result / count selection for an accepted start
    // -------------------------------------------------------------------------
    logic [63:0] result_next;
    logic [3:0]  load_count;

    assign result_next = is_div ? div_result : mul_result;
    assign load_count  = is_div ? DIV_LOAD : MULT_LOAD;

    // -------------------------------------------------------------------------
    // Control FSM and architectural registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            busy_reg    <= 1'b0;
            counter_reg <= 4'd0;
            pending_reg <= 64'd0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (cancel_req) begin
                        // Flush in progress: nothing from EX may take effect.
                    end else if (start) begin
                        // start beats a simultaneous move.
                        state_reg   <= RUN;
                        busy_reg    <= 1'b1;
                        counter_reg <= load_count;
                        pending_reg <= result_next;
                    end else begin
                        if (mthi) begin
                            hi_reg <= a;
                        end
                        if (mtlo) begin
                            lo_reg <= a;
                        end
                    end
                end

                RUN: begin
                    // start/mthi/mtlo are deliberately ignored for the whole
                    // run, including the final commit edge.
                    if (cancel_req) begin
                        state_reg   <= IDLE;
                        busy_reg    <= 1'b0;
                        counter_reg <= 4'd0;
                        pending_reg <= 64'd0;
                    end else if (counter_reg == 4'd0) begin
                        state_reg   <= IDLE;
                        busy_reg    <= 1'b0;
                        hi_reg      <= pending_reg[63:32];
                        lo_reg      <= pending_reg[31:0];
                        pending_reg <= 64'd0;
                    end else begin
                        counter_reg <= counter_reg - 4'd1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_reg;
    assign md_pending = start | busy_reg;
    assign hi         = hi_reg;
    assign lo         = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// -----------------------------------------------------------------------------
// tb_md_unit -- scoreboard bench for md_unit (default parameters 5 / 10).
//
// The driver issues directed operations with hand-computed results and pushes
// two kinds of expectations: a commit record (busy length, HI, LO) consumed
// when busy falls, and probe records (busy, md_pending, HI, LO) consumed at
// the next falling clock edge. The monitor also logs any request made while
// busy; the total of such requests is checked at the end.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  md_op = 2'b00;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        md_pending;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MD_CANCEL_EN
    logic        cancel = 1'b0;
`endif

    md_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .md_op      (md_op),
        .mthi       (mthi),
        .mtlo       (mtlo),
`ifdef MD_CANCEL_EN
        .cancel     (cancel),
`endif
        .a          (a),
        .b          (b),
        .busy       (busy),
        .md_pending (md_pending),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } commit_t;

    typedef struct {
        string       name;
        logic        busy;
        logic        pend;
        logic [31:0] hi;
        logic [31:0] lo;
    } probe_t;

    commit_t     commit_q[$];
    probe_t      probe_q[$];
    int          total = 0;
    int          bad = 0;
    int          illegal_seen = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input string nm, input logic bz, input logic pd,
                         input logic [31:0] h, input logic [31:0] l);
        probe_t p;
        p.name = nm;
        p.busy = bz;
        p.pend = pd;
        p.hi   = h;
        p.lo   = l;
        probe_q.push_back(p);
    endtask

    // inj: 0 none, 1 mthi in 2nd busy cycle, 2 start in last busy cycle,
    //      3 mthi together with start
    task automatic do_op(input string nm, input logic [1:0] op,
                         input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] eh, input logic [31:0] el,
                         input int n, input int inj);
        commit_t c;
        c.name   = nm;
        c.hi     = eh;
        c.lo     = el;
        c.cycles = n;
        md_op = op;
        a     = av;
        b     = bv;
        start = 1'b1;
        if (inj == 3) mthi = 1'b1;
        commit_q.push_back(c);
        probe({nm, "_startcyc"}, 1'b0, 1'b1, model_hi, model_lo);
        tick();
        start = 1'b0;
        mthi  = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        for (int k = 1; k <= n; k++) begin
            if (k == 2) probe({nm, "_run"}, 1'b1, 1'b1, model_hi, model_lo);
            if (inj == 1 && k == 2) begin
                mthi = 1'b1;
                a    = 32'hDEAD_BEEF;
            end
            if (inj == 2 && k == n) begin
                start = 1'b1;
                md_op = 2'b11;
                a     = 32'd9;
                b     = 32'd3;
            end
            tick();
            mthi  = 1'b0;
            start = 1'b0;
            a     = 32'd0;
            b     = 32'd0;
        end
        model_hi = eh;
        model_lo = el;
        probe({nm, "_done"}, 1'b0, 1'b0, eh, el);
        tick();
    endtask

    task automatic do_move(input string nm, input logic h, input logic l, input logic [31:0] av);
        mthi = h;
        mtlo = l;
        a    = av;
        tick();
        mthi = 1'b0;
        mtlo = 1'b0;
        a    = 32'd0;
        if (h) model_hi = av;
        if (l) model_lo = av;
        probe(nm, 1'b0, 1'b0, model_hi, model_lo);
        tick();
    endtask

    // Monitor: consumes expectations as the DUT presents results.
    initial begin : monitor
        int      run_len;
        logic    busy_prev;
        commit_t ce;
        probe_t  pe;
        run_len   = 0;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) run_len++;
            if (busy_prev && busy !== 1'b1) begin
                if (commit_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_commit: busy fell after %0d cycles, required no operation", run_len);
                end else begin
                    ce = commit_q.pop_front();
                    chk({ce.name, "_cycles"}, 32'(run_len), 32'(ce.cycles));
                    chk({ce.name, "_hi"}, hi, ce.hi);
                    chk({ce.name, "_lo"}, lo, ce.lo);
                    $display("commit %s: cycles=%0d hi=0x%08h lo=0x%08h", ce.name, run_len, hi, lo);
                end
                run_len = 0;
            end
            busy_prev = (busy === 1'b1);
            if (probe_q.size() != 0) begin
                pe = probe_q.pop_front();
                chk({pe.name, "_busy"}, 32'(busy), 32'(pe.busy));
                chk({pe.name, "_pending"}, 32'(md_pending), 32'(pe.pend));
                chk({pe.name, "_hi"}, hi, pe.hi);
                chk({pe.name, "_lo"}, lo, pe.lo);
                $display("probe %s: busy=%b pending=%b hi=0x%08h lo=0x%08h", pe.name, busy, md_pending, hi, lo);
            end
            if (busy === 1'b1 && (start || mthi || mtlo)) begin
                illegal_seen++;
                $display("illegal request while busy: start=%b mthi=%b mtlo=%b", start, mthi, mtlo);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        commit_t c;
        repeat (3) tick();
        reset_n = 1'b1;
        probe("reset_state", 1'b0, 1'b0, 32'd0, 32'd0);
        tick();

        do_op("mult_neg2x3",   2'b00, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 0);
        do_op("multu_max",     2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5, 0);
        do_op("div_neg7_2",    2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 0);
        do_op("divu_7_by0",    2'b11, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 10, 0);
        do_op("div_overflow",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10, 0);
        do_op("div_7_neg2",    2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10, 0);
        do_op("div_neg7_by0",  2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 10, 0);
        do_op("divu_100_7_lastedge_start", 2'b11, 32'd100, 32'd7,   32'd2,         32'd14,        10, 2);

        do_move("mthi_idle", 1'b1, 1'b0, 32'h1234_5678);
        do_move("mtlo_idle", 1'b0, 1'b1, 32'hCAFE_F00D);
        do_move("mthi_mtlo_both", 1'b1, 1'b1, 32'h0BAD_BEEF);

        do_op("mult_6x7_with_mthi",  2'b00, 32'd6, 32'd7, 32'd0, 32'h0000_002A, 5, 3);
        do_op("multu_3x5_mthi_busy", 2'b01, 32'd3, 32'd5, 32'd0, 32'h0000_000F, 5, 1);

        // Reset in the 4th busy cycle of a DIV: abort, clear, no later commit.
        c.name   = "reset_abort";
        c.hi     = 32'd0;
        c.lo     = 32'd0;
        c.cycles = 3;
        commit_q.push_back(c);
        md_op = 2'b10;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        tick();
        tick();
        tick();
        reset_n  = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        probe("reset_abort_now", 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        repeat (14) tick();
        probe("reset_abort_nocommit", 1'b0, 1'b0, 32'd0, 32'd0);
        tick();

`ifdef MD_CANCEL_EN
        do_op("mult_6x7_precancel", 2'b00, 32'd6, 32'd7, 32'd0, 32'h0000_002A, 5, 0);
        c.name   = "cancel_mult";
        c.hi     = model_hi;
        c.lo     = model_lo;
        c.cycles = 2;
        commit_q.push_back(c);
        md_op = 2'b00;
        a     = 32'd5;
        b     = 32'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        probe("cancel_idle", 1'b0, 1'b0, model_hi, model_lo);
        tick();
        cancel = 1'b1;
        mthi   = 1'b1;
        a      = 32'h0000_0055;
        tick();
        cancel = 1'b0;
        mthi   = 1'b0;
        a      = 32'd0;
        probe("cancel_blocks_move", 1'b0, 1'b0, model_hi, model_lo);
        tick();
`endif

        for (int i = 0; i < 100 && (commit_q.size() != 0 || probe_q.size() != 0); i++) tick();
        chk("commit_queue_drained", 32'(commit_q.size()), 32'd0);
        chk("probe_queue_drained", 32'(probe_q.size()), 32'd0);
        chk("illegal_request_count", 32'(illegal_seen), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
